genbuf_dbw_rr_monitor: RTL and testbench



---
 rtl/genbuf_dbw_rr_monitor.sv | 167 ++++++++++++++++
 tb/tb_genbuf_dbw_rr_monitor.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/genbuf_dbw_rr_monitor.sv
// -----------------------------------------------------------------------------
// genbuf_dbw_rr_monitor
//
// Purpose:
//   Non-intrusive checker that sits beside the GenBuf controller. It tracks
//   two properties in registered state:
//     * Round-robin ordering of buffer-to-receiver requests over NUM_RECV
//       receivers. Each request phase must target the expected receiver,
//       hold one-hot on that receiver, and end with an idle cycle. The
//       expected receiver then advances with wrap-around. Any other pattern
//       drops the monitor into a sticky error state that only rst clears.
//     * The dequeue-pending obligation. A non-empty buffer raises it and only
//       DEQ clears it. A saturating counter measures how long the obligation
//       has been outstanding and raises starve_warn when the counter
//       saturates.
//   Every output is a register or a pure decode of registers, so each input
//   affects the outputs exactly one cycle later.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   BtoR_REQ     in   [NUM_RECV-1:0] request lines, buffer to receiver i
//   EMPTY        in   buffer empty
//   DEQ          in   dequeue strobe
//   exp_idx      out  [IDXW-1:0] receiver expected to be served next
//   rr_active    out  a request phase is in progress
//   rr_done      out  one-cycle pulse: request phase completed legally
//   rr_err       out  sticky ordering violation
//   deq_pending  out  dequeue obligation outstanding
//   wait_cnt     out  [CNTW-1:0] consecutive pending cycles, saturating
//   starve_warn  out  wait_cnt has reached MAX_WAIT
//   accept       out  no pending obligation and no ordering error
// -----------------------------------------------------------------------------
module genbuf_dbw_rr_monitor #(
  parameter int NUM_RECV = 2,
  parameter int MAX_WAIT = 4,
  parameter int IDXW     = $clog2(NUM_RECV),
  parameter int CNTW     = $clog2(MAX_WAIT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_RECV-1:0] BtoR_REQ,
  input  logic                EMPTY,
  input  logic                DEQ,
  output logic [IDXW-1:0]     exp_idx,
  output logic                rr_active,
  output logic                rr_done,
  output logic                rr_err,
  output logic                deq_pending,
  output logic [CNTW-1:0]     wait_cnt,
  output logic                starve_warn,
  output logic                accept
);

  typedef enum logic [1:0] {
    RR_IDLE   = 2'd0,
    RR_ACTIVE = 2'd1,
    RR_ERR    = 2'd2
  } rr_state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_RECV - 1);
  localparam logic [CNTW-1:0] WAIT_MAX = CNTW'(MAX_WAIT);

  rr_state_t     state, state_n;
  logic [IDXW-1:0] cur_idx, cur_idx_n, exp_idx_n;
  logic            rr_done_n;
  logic            deq_pending_n;
  logic [CNTW-1:0] wait_cnt_n;

  // One-hot masks of the receiver the monitor will accept in each state.
  logic [NUM_RECV-1:0] exp_mask, cur_mask;
  assign exp_mask = NUM_RECV'(1) << exp_idx;
  assign cur_mask = NUM_RECV'(1) << cur_idx;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RR_IDLE;
      exp_idx     <= '0;
      cur_idx     <= '0;
      rr_done     <= 1'b0;
      deq_pending <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state       <= state_n;
      exp_idx     <= exp_idx_n;
      cur_idx     <= cur_idx_n;
      rr_done     <= rr_done_n;
      deq_pending <= deq_pending_n;
      wait_cnt    <= wait_cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal is given a default before the case statement; a path
  // that left one unassigned would infer a latch.
  always_comb begin
    state_n   = state;
    exp_idx_n = exp_idx;
    cur_idx_n = cur_idx;
    rr_done_n = 1'b0;

    unique case (state)
      RR_IDLE: begin
        if (BtoR_REQ == '0) begin
          state_n = RR_IDLE;
        end else if (BtoR_REQ == exp_mask) begin
          state_n   = RR_ACTIVE;
          cur_idx_n = exp_idx;
        end else begin
          // Multi-hot, or the wrong receiver served out of turn.
          state_n = RR_ERR;
        end
      end

      RR_ACTIVE: begin
        if (BtoR_REQ == cur_mask) begin
          state_n = RR_ACTIVE;
        end else if (BtoR_REQ == '0) begin
          // Phase closed by an idle cycle: accepting visit, advance the turn.
          state_n   = RR_IDLE;
          exp_idx_n = (cur_idx == LAST_IDX) ? '0 : cur_idx + IDXW'(1);
          rr_done_n = 1'b1;
        end else begin
          // Switched receiver without an idle cycle, or an extra bit appeared.
          state_n = RR_ERR;
        end
      end

      RR_ERR: begin
        state_n = RR_ERR;
      end

      default: begin
        state_n = RR_ERR;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Dequeue tracker and saturating wait counter
  // ---------------------------------------------------------------------------
  // DEQ wins over a simultaneous non-empty buffer; EMPTY alone never clears
  // an obligation that is already outstanding.
  always_comb begin
    deq_pending_n = (deq_pending | ~EMPTY) & ~DEQ;
    wait_cnt_n    = '0;
    if (deq_pending_n) begin
      wait_cnt_n = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + CNTW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output decodes
  // ---------------------------------------------------------------------------
  assign rr_active   = (state == RR_ACTIVE);
  assign rr_err      = (state == RR_ERR);
  assign starve_warn = (wait_cnt == WAIT_MAX);
  assign accept      = ~deq_pending & ~rr_err;

endmodule

// File: tb/tb_genbuf_dbw_rr_monitor.sv
// -----------------------------------------------------------------------------
// tb_genbuf_dbw_rr_monitor
//
// Self-checking bench for genbuf_dbw_rr_monitor with NUM_RECV=3, MAX_WAIT=4.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge and compared against a behavioural model kept in integers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_genbuf_dbw_rr_monitor;

  localparam int NUM_RECV = 3;
  localparam int MAX_WAIT = 4;
  localparam int IDXW     = $clog2(NUM_RECV);
  localparam int CNTW     = $clog2(MAX_WAIT + 1);
  localparam int VW       = IDXW + CNTW + 6;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NUM_RECV-1:0] BtoR_REQ = '0;
  logic                EMPTY = 1'b1;
  logic                DEQ = 1'b0;
  logic [IDXW-1:0]     exp_idx;
  logic                rr_active;
  logic                rr_done;
  logic                rr_err;
  logic                deq_pending;
  logic [CNTW-1:0]     wait_cnt;
  logic                starve_warn;
  logic                accept;

  int checks   = 0;
  int failures = 0;

  genbuf_dbw_rr_monitor #(
    .NUM_RECV(NUM_RECV),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .BtoR_REQ   (BtoR_REQ),
    .EMPTY      (EMPTY),
    .DEQ        (DEQ),
    .exp_idx    (exp_idx),
    .rr_active  (rr_active),
    .rr_done    (rr_done),
    .rr_err     (rr_err),
    .deq_pending(deq_pending),
    .wait_cnt   (wait_cnt),
    .starve_warn(starve_warn),
    .accept     (accept)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: the turn is an integer that advances modulo NUM_RECV,
  // the current phase is remembered as the receiver number being served
  // (-1 when no phase is open), and the wait is a plain integer count.
  // ---------------------------------------------------------------------------
  int m_turn;      // receiver whose turn is next
  int m_serving;   // receiver currently being served, -1 if none
  bit m_broken;    // an ordering rule has been violated since reset
  bit m_done;
  bit m_pend;
  int m_wait;

  task automatic model_reset();
    m_turn    = 0;
    m_serving = -1;
    m_broken  = 0;
    m_done    = 0;
    m_pend    = 0;
    m_wait    = 0;
  endtask

  task automatic model_step(input int req, input bit empty, input bit deq);
    m_done = 0;
    if (!m_broken) begin
      if (m_serving < 0) begin
        if (req == 0) begin
          // no phase, nothing happens
        end else if (req == (1 << m_turn)) begin
          m_serving = m_turn;
        end else begin
          m_broken = 1;
        end
      end else begin
        if (req == (1 << m_serving)) begin
          // phase continues
        end else if (req == 0) begin
          m_turn    = (m_serving + 1) % NUM_RECV;
          m_serving = -1;
          m_done    = 1;
        end else begin
          m_broken = 1;
        end
      end
    end
    m_pend = (m_pend || !empty) && !deq;
    m_wait = m_pend ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
  endtask

  function automatic logic [VW-1:0] model_vec();
    return {IDXW'(m_turn), (m_serving >= 0) && !m_broken, m_done, m_broken,
            m_pend, CNTW'(m_wait), m_wait == MAX_WAIT, !m_pend && !m_broken};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {exp_idx, rr_active, rr_done, rr_err, deq_pending, wait_cnt,
            starve_warn, accept};
  endfunction

  // Packed reset image: exp_idx=0, all flags 0, wait_cnt=0, accept=1.
  localparam logic [VW-1:0] RESET_VEC = {{(VW-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Stimulus primitives
  // ---------------------------------------------------------------------------
  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    BtoR_REQ = '0;
    EMPTY    = 1'b1;
    DEQ      = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drive(input int req, input bit empty, input bit deq);
    @(negedge clk);
    BtoR_REQ = NUM_RECV'(req);
    EMPTY    = empty;
    DEQ      = deq;
    @(posedge clk);
    #1;
    model_step(req, empty, deq);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec(), RESET_VEC);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 1'b1, 1'b0);
      checks++;
      if (dut_vec() !== RESET_VEC) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, dut_vec(), RESET_VEC);
      end
    end
  endtask

  task automatic test_rotation();
    int seq [8] = '{1, 1, 0, 2, 0, 4, 0, 1};
    int exp_after [3] = '{1, 2, 0};
    int done_cnt = 0;
    apply_reset();
    foreach (seq[i]) begin
      drive(seq[i], 1'b1, 1'b0);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL rotation cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
      end
      if (rr_done === 1'b1) begin
        if (done_cnt < 3) begin
          checks++;
          if (exp_idx !== IDXW'(exp_after[done_cnt])) begin
            failures++;
            $display("FAIL rotation_exp_idx pulse=%0d got=%0d exp=%0d",
                     done_cnt, exp_idx, exp_after[done_cnt]);
          end
        end
        done_cnt++;
      end
    end
    checks++;
    if (done_cnt != 3) begin
      failures++;
      $display("FAIL rotation_done_count got=%0d exp=3", done_cnt);
    end
    checks++;
    if (rr_active !== 1'b1 || rr_err !== 1'b0) begin
      failures++;
      $display("FAIL rotation_final got active=%b err=%b exp active=1 err=0",
               rr_active, rr_err);
    end
  endtask

  task automatic test_violations();
    // Each scenario: prefix of requests; the last one is the violation.
    int scen [3][2] = '{'{2, -1}, '{1, 2}, '{3, -1}};
    string names [3] = '{"wrong_first", "switch_no_idle", "multi_hot"};
    int legal [10] = '{1, 0, 2, 0, 4, 0, 1, 1, 0, 2};
    for (int s = 0; s < 3; s++) begin
      apply_reset();
      for (int k = 0; k < 2; k++) begin
        if (scen[s][k] >= 0) drive(scen[s][k], 1'b1, 1'b0);
      end
      checks++;
      if (rr_err !== 1'b1 || accept !== 1'b0 || rr_active !== 1'b0) begin
        failures++;
        $display("FAIL viol_%s got err=%b acc=%b act=%b exp err=1 acc=0 act=0",
                 names[s], rr_err, accept, rr_active);
      end
      if (s == 0) begin
        for (int i = 0; i < 10; i++) begin
          drive(legal[i], 1'b1, 1'b0);
          checks++;
          if (rr_err !== 1'b1 || rr_done !== 1'b0 || dut_vec() !== model_vec()) begin
            failures++;
            $display("FAIL viol_sticky cyc=%0d got=%b exp=%b", i, dut_vec(), model_vec());
          end
        end
      end
      apply_reset();
      checks++;
      if (dut_vec() !== RESET_VEC) begin
        failures++;
        $display("FAIL viol_%s_reset got=%b exp=%b", names[s], dut_vec(), RESET_VEC);
      end
    end
  endtask

  task automatic test_starvation();
    int exp_wait [6] = '{1, 2, 3, 4, 4, 4};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b0, 1'b0);
      checks++;
      if (wait_cnt !== CNTW'(exp_wait[i]) || deq_pending !== 1'b1 ||
          starve_warn !== (i >= 3) || accept !== 1'b0) begin
        failures++;
        $display("FAIL starve cyc=%0d got cnt=%0d pend=%b warn=%b acc=%b exp cnt=%0d pend=1 warn=%b acc=0",
                 i, wait_cnt, deq_pending, starve_warn, accept, exp_wait[i], i >= 3);
      end
    end
    drive(0, 1'b0, 1'b1);
    checks++;
    if (deq_pending !== 1'b0 || wait_cnt !== '0 || accept !== 1'b1 ||
        starve_warn !== 1'b0) begin
      failures++;
      $display("FAIL starve_deq got pend=%b cnt=%0d acc=%b warn=%b exp pend=0 cnt=0 acc=1 warn=0",
               deq_pending, wait_cnt, accept, starve_warn);
    end
  endtask

  task automatic test_simultaneous();
    int exp_wait [3] = '{1, 2, 3};
    apply_reset();
    drive(0, 1'b0, 1'b1);
    checks++;
    if (deq_pending !== 1'b0 || wait_cnt !== '0) begin
      failures++;
      $display("FAIL simul_deq_wins got pend=%b cnt=%0d exp pend=0 cnt=0",
               deq_pending, wait_cnt);
    end
    drive(0, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0);
    checks++;
    if (deq_pending !== 1'b1 || wait_cnt !== CNTW'(exp_wait[2])) begin
      failures++;
      $display("FAIL pend_held got pend=%b cnt=%0d exp pend=1 cnt=%0d",
               deq_pending, wait_cnt, exp_wait[2]);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    drive(1, 1'b1, 1'b0);
    drive(0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(2, 1'b0, 1'b0);
    checks++;
    if (rr_active !== 1'b1 || exp_idx !== IDXW'(1) || wait_cnt !== CNTW'(3)) begin
      failures++;
      $display("FAIL async_pre got act=%b idx=%0d cnt=%0d exp act=1 idx=1 cnt=3",
               rr_active, exp_idx, wait_cnt);
    end
    // Now 1 ns past the rising edge; assert reset well before the next one.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b", dut_vec(), RESET_VEC);
    end
    @(negedge clk);
    BtoR_REQ = '0;
    EMPTY    = 1'b1;
    rst      = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int req, pick;
    bit empty, deq;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (i % 60 == 59) apply_reset();
      pick = $urandom_range(0, 9);
      if (pick <= 3)      req = 0;
      else if (pick <= 5) req = 1 << m_turn;
      else if (pick <= 7) req = (m_serving >= 0) ? (1 << m_serving) : 0;
      else if (pick == 8) req = $urandom_range(0, 7);
      else                req = 1 << $urandom_range(0, NUM_RECV - 1);
      empty = ($urandom_range(0, 1) == 1);
      deq   = ($urandom_range(0, 3) == 0);
      drive(req, empty, deq);
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d req=%0d empty=%b deq=%b got=%b exp=%b",
                 i, req, empty, deq, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_violations();
    test_starvation();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
